// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, limits and FSM state type for the Booth result accumulator
//
// Purpose: constants and types shared by booth_result_accum and booth_sat_add.
//   PROD_W   : signed product width of the 8x8 Booth multiplier
//   ACC_W    : accumulator / result width
//   MAX_LEN  : longest accumulation (products per result)
//   LEN_W    : width of the acc_len request field
//   state_t  : ST_ACC (collecting), ST_OUT (presenting)
//   norm_len : maps out-of-range acc_len values (0, >MAX_LEN) to MAX_LEN
package booth_pkg;

  localparam int PROD_W  = 16;
  localparam int ACC_W   = 18;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// rtl/booth_sat_add.sv - W-bit signed adder with overflow flag and optional clamp
//
// Purpose: one accumulation step, sum = a + b in two's complement.
// Build option: BOOTH_ACC_SAT_EN defined -> on overflow the sum clamps to the
//   most positive / most negative W-bit value in the overflow direction;
//   undefined -> the sum wraps modulo 2^W. The ovf flag is the same in both builds.
// Ports:
//   a   in  W  current accumulator value
//   b   in  W  sign-extended addend
//   sum out W  next accumulator value
//   ovf out 1  this addition overflowed
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int W = booth_pkg::ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;

  // Same-sign operands whose raw sum changes sign have left the W-bit range.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

  always_comb begin
    sum = raw;
`ifdef BOOTH_ACC_SAT_EN
    // Both operands share a sign on overflow, so a's sign gives the direction.
    if (ovf) begin
      sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`else
`endif
  end

endmodule

// File: rtl/booth_result_accum.sv
// rtl/booth_result_accum.sv - accumulates Booth multiplier products into signed results
//
// Purpose: sums acc_len signed products (or fewer when flushed) and presents
//   the total with a valid/ready handshake and a sticky overflow flag.
// Build option: BOOTH_ACC_SAT_EN (see booth_sat_add) selects saturating
//   instead of wrapping accumulation.
// Ports:
//   clk        in  1       clock, rising edge
//   rst        in  1       synchronous active-high reset
//   prod       in  PROD_W  signed product
//   prod_valid in  1       prod valid
//   prod_ready out 1       product accepted this cycle (collecting)
//   acc_len    in  5       products per result, 0 and >16 mean 16
//   flush      in  1       close a non-empty accumulation early
//   acc_out    out ACC_W   signed result
//   acc_valid  out 1       result presented
//   acc_ready  in  1       consumer takes the result
//   ovf        out 1       overflow occurred in the presented result
module booth_result_accum
  import booth_pkg::*;
#(
  parameter int ACC_W  = booth_pkg::ACC_W,
  parameter int PROD_W = booth_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf
);

  state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] eff_len;
  logic             accept;
  logic             consume;

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign accept   = prod_valid && (state_q == ST_ACC);
  assign consume  = acc_ready && (state_q == ST_OUT);
  assign cnt_inc  = cnt_q + LEN_W'(1);

  // len_q is only loaded at the end of the cnt==0 cycle, so the first
  // acceptance must already compare against the freshly requested length.
  assign eff_len  = (cnt_q == '0) ? norm_len(acc_len) : len_q;

  booth_sat_add #(
    .W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        // A same-cycle flush still counts the product, leaving cnt > 0.
        if (accept && (cnt_inc == eff_len || flush)) begin
          state_d = ST_OUT;
        end else if (flush && cnt_q != '0) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (acc_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      len_q <= LEN_W'(MAX_LEN);
    end else begin
      if (state_q == ST_ACC && cnt_q == '0) begin
        len_q <= norm_len(acc_len);
      end
      if (consume) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        acc_q <= add_sum;
        cnt_q <= cnt_inc;
        ovf_q <= ovf_q | add_ovf;
      end
    end
  end

  assign prod_ready = (state_q == ST_ACC);
  assign acc_valid  = (state_q == ST_OUT);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q && (state_q == ST_OUT);

endmodule

// File: tb/tb_booth_result_accum.sv
// tb/tb_booth_result_accum.sv - self-checking bench for booth_result_accum
module tb_booth_result_accum;

  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;
  localparam longint MODV = 262144;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prod;
  logic        prod_valid;
  logic        prod_ready;
  logic [4:0]  acc_len;
  logic        flush;
  logic [17:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_result_accum dut (
    .clk        (clk),
    .rst        (rst),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_len    (acc_len),
    .flush      (flush),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf        (ovf)
  );

  typedef struct {
    int     len;
    int     n;
    longint a;
    longint b;
    longint c;
    bit     fl;
    longint exp_out;
    bit     exp_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic longint out_s();
    return longint'($signed(acc_out));
  endfunction

  // Reference: integer running sum, clamped or folded back into 18 bits
  // whenever it leaves the representable range.
  function automatic void model(input longint q[$], output longint res, output bit o);
    longint s;
    s = 0;
    o = 1'b0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s > MAXV || s < MINV) begin
        o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
        s = (s > MAXV) ? MAXV : MINV;
`else
        while (s > MAXV) s = s - MODV;
        while (s < MINV) s = s + MODV;
`endif
      end
    end
    res = s;
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic push(input longint v, input bit fl);
    check("prod_ready_before_push", prod_ready, 1);
    prod       = v[15:0];
    prod_valid = 1'b1;
    flush      = fl;
    @(negedge clk);
    prod_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic consume();
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check("consume_valid_low", acc_valid, 0);
    check("consume_ready_high", prod_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    longint q[$];
    longint v;
    longint er;
    bit     eo;
    int     raw, l, k, mode;
    logic [15:0] r;

    rst = 1'b1; prod = '0; prod_valid = 1'b0; acc_len = '0; flush = 1'b0; acc_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_acc_out", out_s(), 0);
    check("reset_acc_valid", acc_valid, 0);
    check("reset_ovf", ovf, 0);
    check("reset_prod_ready", prod_ready, 1);

    // flush with nothing collected does nothing
    do_flush();
    check("empty_flush_ignored", acc_valid, 0);

    tbl[0] = '{len:4,  n:4,  a:1000,   b:1000,   c:1000,   fl:0, exp_out:4000, exp_ovf:0};
`ifdef BOOTH_ACC_SAT_EN
    tbl[1] = '{len:0,  n:16, a:16384,  b:16384,  c:16384,  fl:0, exp_out:131071,  exp_ovf:1};
    tbl[2] = '{len:16, n:16, a:-16256, b:-16256, c:-16256, fl:0, exp_out:-131072, exp_ovf:1};
    tbl[5] = '{len:20, n:16, a:-32768, b:-32768, c:-32768, fl:0, exp_out:-131072, exp_ovf:1};
`else
    tbl[1] = '{len:0,  n:16, a:16384,  b:16384,  c:16384,  fl:0, exp_out:0,    exp_ovf:1};
    tbl[2] = '{len:16, n:16, a:-16256, b:-16256, c:-16256, fl:0, exp_out:2048, exp_ovf:1};
    tbl[5] = '{len:20, n:16, a:-32768, b:-32768, c:-32768, fl:0, exp_out:0,    exp_ovf:1};
`endif
    tbl[3] = '{len:5,  n:2,  a:10,     b:20,     c:0,      fl:1, exp_out:30,    exp_ovf:0};
    tbl[4] = '{len:1,  n:1,  a:32767,  b:0,      c:0,      fl:0, exp_out:32767, exp_ovf:0};
    tbl[6] = '{len:3,  n:3,  a:100,    b:-200,   c:50,     fl:0, exp_out:-50,   exp_ovf:0};

    foreach (tbl[t]) begin
      acc_len = 5'(tbl[t].len);
      for (int i = 0; i < tbl[t].n; i++) begin
        v = (i == 0) ? tbl[t].a : (i == 1) ? tbl[t].b : tbl[t].c;
        if (i == tbl[t].n - 1) begin
          push(v, tbl[t].fl);
        end else begin
          push(v, 1'b0);
          check($sformatf("tbl%0d_not_done", t), acc_valid, 0);
        end
      end
      check($sformatf("tbl%0d_valid", t), acc_valid, 1);
      check($sformatf("tbl%0d_out", t), out_s(), tbl[t].exp_out);
      check($sformatf("tbl%0d_ovf", t), ovf, tbl[t].exp_ovf);
      consume();
    end

    // separate flush, long stall with products offered, restart from zero
    acc_len = 5'd8;
    push(7, 1'b0);
    push(-3, 1'b0);
    check("flush_seq_not_done", acc_valid, 0);
    do_flush();
    check("flush_seq_valid", acc_valid, 1);
    check("flush_seq_out", out_s(), 4);
    prod = 16'd999;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out", out_s(), 4);
      check("stall_prod_ready", prod_ready, 0);
      check("stall_valid", acc_valid, 1);
    end
    // product still offered in the consume cycle must be dropped
    consume();
    prod_valid = 1'b0;
    acc_len = 5'd2;
    push(1, 1'b0);
    push(2, 1'b0);
    check("restart_valid", acc_valid, 1);
    check("restart_out", out_s(), 3);
    consume();

    // acc_len changes after the first product are ignored
    acc_len = 5'd2;
    push(10, 1'b0);
    acc_len = 5'd5;
    push(20, 1'b0);
    check("len_latch_valid", acc_valid, 1);
    check("len_latch_out", out_s(), 30);
    consume();

    // reset mid-accumulation discards partial sum
    acc_len = 5'd3;
    push(5, 1'b0);
    push(5, 1'b0);
    do_reset();
    check("midrst_valid", acc_valid, 0);
    check("midrst_out", out_s(), 0);
    check("midrst_ready", prod_ready, 1);
    push(5, 1'b0);
    push(5, 1'b0);
    push(5, 1'b0);
    check("after_rst_valid", acc_valid, 1);
    check("after_rst_out", out_s(), 15);
    // reset while presenting
    do_reset();
    check("outrst_valid", acc_valid, 0);
    check("outrst_ovf", ovf, 0);

    // randomized runs against the reference model
    for (int trial = 0; trial < 40; trial++) begin
      raw  = int'($urandom_range(0, 31));
      l    = (raw == 0 || raw > 16) ? 16 : raw;
      k    = int'($urandom_range(1, l));
      mode = int'($urandom_range(0, 1));
      acc_len = 5'(raw);
      q.delete();
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
        end
        if ($urandom_range(0, 1) == 0) begin
          r = 16'($urandom);
          v = longint'($signed(r));
        end else begin
          v = longint'($urandom_range(0, 200)) - 100;
        end
        q.push_back(v);
        push(v, (i == k - 1) && (k < l) && (mode == 0));
      end
      if (k < l && mode == 1) begin
        check("rnd_early", acc_valid, 0);
        do_flush();
      end
      model(q, er, eo);
      check($sformatf("rnd%0d_valid", trial), acc_valid, 1);
      check($sformatf("rnd%0d_out", trial), out_s(), er);
      check($sformatf("rnd%0d_ovf", trial), ovf, eo);
      for (int s = int'($urandom_range(0, 3)); s > 0; s--) begin
        @(negedge clk);
        check("rnd_hold_out", out_s(), er);
      end
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
